// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that sequences a single-port data RAM.
// Each transaction takes three cycles: IDLE (arbitrate), ISSUE (drive the RAM), DONE (ack).
module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [1:0]                  grant_id,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_r;
  logic [1:0]          ptr_r;
  logic [1:0]          grant_id_r;
  logic                we_r;
  logic                busy_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [DATA_W-1:0]   rdata_hold_r;
  logic [NUM_REQ-1:0]  ack_r;

  logic [1:0]          winner_s;
  logic                found_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [DATA_W-1:0]   rdata_s;
  int                  dist_s;
  int                  best_dist_s;

  // Round-robin pick: smallest rotated distance after ptr wins, then mux its request fields.
  always_comb begin
    winner_s    = 2'd0;
    found_s     = 1'b0;
    dist_s      = 0;
    best_dist_s = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = (i - int'(ptr_r) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (req[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        winner_s    = 2'(i);
        found_s     = 1'b1;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (2'(i) == winner_s) begin
        sel_we_s    = req_we[i];
        sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_s = req_wdata[i*DATA_W +: DATA_W];
      end else begin
        sel_we_s    = sel_we_s;
      end
    end
  end

  // Transaction sequencer with registered RAM controls and ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ptr_r        <= 2'(NUM_REQ - 1);
      grant_id_r   <= 2'd0;
      we_r         <= 1'b0;
      busy_r       <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      rdata_hold_r <= '0;
      ack_r        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= '0;
          if (found_s) begin
            grant_id_r  <= winner_s;
            we_r        <= sel_we_s;
            mem_en_r    <= 1'b1;
            mem_we_r    <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            busy_r      <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          ptr_r    <= grant_id_r;
          for (int i = 0; i < NUM_REQ; i++) begin
            ack_r[i] <= (i == int'(grant_id_r));
          end
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          ack_r   <= '0;
          busy_r  <= 1'b0;
          if (!we_r) begin
            rdata_hold_r <= mem_rdata;
          end else begin
            rdata_hold_r <= rdata_hold_r;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r    <= '0;
          busy_r   <= 1'b0;
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM read data only arrives during DONE, so it is forwarded then and held afterwards.
  always_comb begin
    if ((state_r == ST_DONE) && !we_r) begin
      rdata_s = mem_rdata;
    end else begin
      rdata_s = rdata_hold_r;
    end
  end

  assign ack       = ack_r;
  assign rdata     = rdata_s;
  assign busy      = busy_r;
  assign grant_id  = grant_id_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
